vle_alu: RTL and testbench

- Parameterised n-bit integer ALU for the VLE datapath: add/subtract with carry-in, bitwise logic, logical and arithmetic shifts, and unsigned/signed multiply (low half).
- Produces carry, signed-overflow, sign and zero flags for the branch/flag logic.
- Result and flags are registered: one clock, asynchronous active-high reset, fixed 1-cycle latency.

---
 rtl/vle_alu.sv | 117 +++++++++++
 tb/tb_vle_alu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vle_alu.sv
// vle_alu: n-bit integer ALU (add/sub with carry, logic, shifts, low-half multiply).
// Result and carry/overflow/sign/zero flags are registered with one cycle of latency.
module vle_alu #(
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [5:0]   op,
    input  logic         cin,
    output logic [n-1:0] out,
    output logic         cout,
    output logic         overflow,
    output logic         sign,
    output logic         zero
);

    localparam logic [4:0] OpAdd = 5'd0;
    localparam logic [4:0] OpSub = 5'd1;
    localparam logic [4:0] OpAnd = 5'd2;
    localparam logic [4:0] OpOr  = 5'd3;
    localparam logic [4:0] OpXor = 5'd4;
    localparam logic [4:0] OpLsl = 5'd5;
    localparam logic [4:0] OpLsr = 5'd6;
    localparam logic [4:0] OpAsr = 5'd7;
    localparam logic [4:0] OpMul = 5'd8;

    // Shift amount compared at no less than 32 bits so b >= n works for any n.
    localparam int unsigned ShW = (n > 32) ? n : 32;

    logic [n:0]     sum;
    logic [n:0]     diff;
    logic [2*n-1:0] prod_u;
    logic [2*n-1:0] prod_s;
    logic [ShW-1:0] sh_amt;
    logic           sh_big;
    logic [n-1:0]   lsl_res;
    logic [n-1:0]   lsr_res;
    logic [n-1:0]   asr_res;

    assign sum     = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
    assign diff    = {1'b0, a} - {1'b0, b} - {{n{1'b0}}, cin};
    assign prod_u  = {{n{1'b0}}, a} * {{n{1'b0}}, b};
    assign prod_s  = $signed({{n{a[n-1]}}, a}) * $signed({{n{b[n-1]}}, b});
    assign sh_amt  = ShW'(b);
    assign sh_big  = sh_amt >= ShW'(n);
    assign lsl_res = sh_big ? '0 : (a << b);
    assign lsr_res = sh_big ? '0 : (a >> b);
    assign asr_res = sh_big ? {n{a[n-1]}} : n'($signed(a) >>> b);

    logic [n-1:0] out_d, out_q;
    logic         cout_d, cout_q;
    logic         overflow_d, overflow_q;
    logic         sign_d, sign_q;
    logic         zero_d, zero_q;

    always_comb begin
        out_d      = '0;
        cout_d     = 1'b0;
        overflow_d = 1'b0;
        unique case (op[4:0])
            OpAdd: begin
                out_d      = sum[n-1:0];
                cout_d     = sum[n];
                overflow_d = (a[n-1] == b[n-1]) && (sum[n-1] != a[n-1]);
            end
            OpSub: begin
                out_d      = diff[n-1:0];
                // Top bit of the (n+1)-bit difference is the borrow.
                cout_d     = diff[n];
                overflow_d = (a[n-1] != b[n-1]) && (diff[n-1] != a[n-1]);
            end
            OpAnd: out_d = a & b;
            OpOr:  out_d = a | b;
            OpXor: out_d = a ^ b;
            OpLsl: out_d = lsl_res;
            OpLsr: out_d = lsr_res;
            OpAsr: out_d = asr_res;
            OpMul: begin
                if (op[5]) begin
                    out_d      = prod_s[n-1:0];
                    overflow_d = prod_s[2*n-1:n] != {n{prod_s[n-1]}};
                end else begin
                    out_d      = prod_u[n-1:0];
                    overflow_d = |prod_u[2*n-1:n];
                end
            end
            default: ;
        endcase
        sign_d = out_d[n-1];
        zero_d = (out_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            out_q      <= out_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            sign_q     <= sign_d;
            zero_q     <= zero_d;
        end
    end

    assign out      = out_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;
    assign sign     = sign_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_vle_alu.sv
// Scoreboard bench for vle_alu: driver pushes model results, monitor pops and compares
// one cycle after each sampled operation.
module tb_vle_alu;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [5:0]   op;
    logic         cin;
    logic [N-1:0] out;
    logic         cout;
    logic         overflow;
    logic         sign;
    logic         zero;

    int total;
    int bad;

    logic [11:0] exp_q[$];
    string       desc_q[$];

    vle_alu #(.n(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .op       (op),
        .cin      (cin),
        .out      (out),
        .cout     (cout),
        .overflow (overflow),
        .sign     (sign),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference built from integer arithmetic: {out, cout, overflow, sign, zero}.
    function automatic logic [11:0] model(int ua, int ub, int opc, int ci);
        int cmd = opc & 31;
        int sg  = (opc >> 5) & 1;
        int sa  = (ua >= 128) ? ua - 256 : ua;
        int sb  = (ub >= 128) ? ub - 256 : ub;
        int r   = 0;
        int c   = 0;
        int v   = 0;
        int t;
        case (cmd)
            0: begin
                t = ua + ub + ci;
                r = t % 256;
                c = (t >= 256) ? 1 : 0;
                t = sa + sb + ci;
                v = (t < -128 || t > 127) ? 1 : 0;
            end
            1: begin
                t = ua - ub - ci;
                r = (t + 512) % 256;
                c = (ua < ub + ci) ? 1 : 0;
                t = sa - sb - ci;
                v = (t < -128 || t > 127) ? 1 : 0;
            end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: r = (ub >= N) ? 0 : ((ua << ub) & 255);
            6: r = (ub >= N) ? 0 : (ua >> ub);
            7: begin
                if (ub >= N) r = (sa < 0) ? 255 : 0;
                else         r = (sa >>> ub) & 255;
            end
            8: begin
                if (sg == 1) begin
                    t = sa * sb;
                    v = (t < -128 || t > 127) ? 1 : 0;
                end else begin
                    t = ua * ub;
                    v = (t > 255) ? 1 : 0;
                end
                r = t & 255;
            end
            default: r = 0;
        endcase
        return {r[7:0], c[0], v[0], (r >= 128) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0};
    endfunction

    task automatic issue(input int ua, input int ub, input int opc, input int ci);
        @(negedge clk);
        a   = ua[N-1:0];
        b   = ub[N-1:0];
        op  = opc[5:0];
        cin = ci[0];
        exp_q.push_back(model(ua, ub, opc, ci));
        desc_q.push_back($sformatf("op=%0d a=%0d b=%0d cin=%0d", opc, ua, ub, ci));
    endtask

    task automatic check_reset(input string name);
        total++;
        if ({out, cout, overflow, sign, zero} !== 12'h000) begin
            bad++;
            $display("FAIL %s: got out=%h c=%b v=%b s=%b z=%b, want all 0",
                     name, out, cout, overflow, sign, zero);
        end
    endtask

    // Monitor: one result per sampled edge, compared after the edge settles.
    always @(posedge clk) begin
        #1;
        if (!rst && exp_q.size() > 0) begin
            logic [11:0] e;
            string       d;
            e = exp_q.pop_front();
            d = desc_q.pop_front();
            total++;
            if ({out, cout, overflow, sign, zero} !== e) begin
                bad++;
                $display("FAIL alu %s: got out=%h c=%b v=%b s=%b z=%b, want out=%h c=%b v=%b s=%b z=%b",
                         d, out, cout, overflow, sign, zero, e[11:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        a     = '0;
        b     = '0;
        op    = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_initial");
        @(negedge clk);
        rst = 1'b0;

        issue(5, 3, 0, 0);
        // Reset mid-operation: outputs clear without waiting for an edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset("reset_async");
        @(posedge clk);
        #1;
        check_reset("reset_held");
        @(negedge clk);
        rst = 1'b0;
        issue(5, 3, 0, 0);

        issue(255, 1, 0, 0);
        issue(127, 127, 0, 0);
        issue(255, 255, 0, 0);
        issue(1, 1, 0, 1);
        issue(1, 2, 1, 0);
        issue(127, 127, 1, 0);
        issue(128, 1, 1, 0);
        issue(255, 255, 1, 0);
        issue(0, 0, 1, 1);
        issue(8'h3A, 2, 5, 0);
        issue(8'h3A, 2, 6, 0);
        issue(8'hBA, 2, 7, 0);
        issue(8'hBA, 9, 7, 0);
        issue(8'h3A, 8, 5, 0);
        issue(8'hBA, 8, 6, 0);
        issue(8'h3A, 0, 7, 1);
        issue(8'h3A, 200, 7, 0);
        issue(10, 12, 8, 0);
        issue(20, 30, 8, 0);
        issue(8'hFD, 7, 8 | 32, 0);
        issue(16, 8, 8 | 32, 0);
        issue(8'hFD, 7, 8, 0);
        issue(8'hF0, 8'h3C, 2 | 32, 1);
        issue(8'hF0, 8'h3C, 3, 1);
        issue(8'hF0, 8'h3C, 4, 0);
        issue(77, 99, 9, 1);
        issue(200, 100, 31 | 32, 1);
        // Back-to-back mix.
        issue(100, 50, 0, 1);
        issue(3, 200, 1, 1);
        issue(250, 250, 8 | 32, 0);
        issue(8'h81, 3, 7, 0);

        for (int i = 0; i < 400; i++) begin
            int opc;
            int ub;
            opc = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 31) : $urandom_range(0, 8);
            if ($urandom_range(0, 1) == 1) opc = opc | 32;
            ub = $urandom_range(0, 255);
            if (opc % 32 >= 5 && opc % 32 <= 7 && $urandom_range(0, 3) != 0) ub = $urandom_range(0, 10);
            issue($urandom_range(0, 255), ub, opc, $urandom_range(0, 1));
        end

        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
